// File: rtl/hid_keycode_packer_pkg.sv
// game_key_pkg: shared FSM states, key codes and Keycode type for the HID packer
package game_key_pkg;
  typedef enum logic [1:0] {IDLE, MOD, KEYS, COMMIT} pack_state_t;
  typedef logic [15:0] keycode_t;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] ROLL_LO   = 8'h01;
  localparam logic [7:0] ROLL_HI   = 8'h03;
endpackage

// File: rtl/hid_key_classify.sv
// hid_key_classify: sorts one HID key byte into player-1, player-2 or rollover-error class
module hid_key_classify
  import game_key_pkg::*;
(
  input  logic [7:0] Byte_In,
  output logic       is_p1,
  output logic       is_p2,
  output logic       is_err
);
  assign is_p2  = Byte_In inside {KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP, KEY_ENTER};
  assign is_err = Byte_In >= ROLL_LO && Byte_In <= ROLL_HI;
  assign is_p1  = |Byte_In && !is_p2 && !is_err;
endmodule

// File: rtl/hid_keycode_packer.sv
// hid_keycode_packer: packs HID boot reports into {p2_key, p1_key}; KEYCODE_EDGE_EN selects new-press-only mode
module hid_keycode_packer
  import game_key_pkg::*;
#(
  parameter int KEY_SLOTS    = 6,
  parameter int REPORT_BYTES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Byte_In,
  input  logic       Byte_Valid,
  output logic       Byte_Ready,
  input  logic       Sof,
  output keycode_t   Keycode,
  output logic       Keycode_Valid,
  output logic       Rollover_Err
);
  localparam int SW = KEY_SLOTS > 1 ? $clog2(KEY_SLOTS) : 1;
  localparam logic [SW-1:0] LAST = SW'(REPORT_BYTES - 3);
  pack_state_t state, state_n;
  logic [SW-1:0] slot;
  logic [7:0] p1, p2;
  logic bad, xfer, is_p1, is_p2, is_err, fresh;
  hid_key_classify u_cls (.Byte_In(Byte_In), .is_p1(is_p1), .is_p2(is_p2), .is_err(is_err));
  assign Byte_Ready = state != COMMIT;
  assign xfer = Byte_Valid && Byte_Ready;
`ifdef KEYCODE_EDGE_EN
  logic [7:0] prev [KEY_SLOTS];
  logic [7:0] cur  [KEY_SLOTS];
  // a key held over from the last good report does not qualify again
  always_comb begin
    fresh = 1'b1;
    for (int i = 0; i < KEY_SLOTS; i++) fresh = fresh && prev[i] != Byte_In;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < KEY_SLOTS; i++) prev[i] <= '0;
    end else begin
      if (xfer && !Sof && state == KEYS) cur[slot] <= Byte_In;
      if (state == COMMIT && !bad) prev <= cur;
    end
  end
`else
  assign fresh = 1'b1;
`endif
  always_comb begin
    state_n = state == COMMIT ? IDLE :
              !xfer           ? state :
              Sof             ? MOD :
              state == MOD    ? KEYS :
              state == KEYS && slot == LAST ? COMMIT : state;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      slot          <= '0;
      p1            <= '0;
      p2            <= '0;
      bad           <= 1'b0;
      Keycode       <= '0;
      Keycode_Valid <= 1'b0;
      Rollover_Err  <= 1'b0;
    end else begin
      state         <= state_n;
      Keycode_Valid <= state == COMMIT && !bad;
      Rollover_Err  <= Rollover_Err || (state == COMMIT && bad);
      if (state == COMMIT && !bad) Keycode <= {p2, p1};
      // Sof always restarts a report, abandoning any partial one
      if (xfer && Sof) begin
        slot <= '0;
        p1   <= '0;
        p2   <= '0;
        bad  <= 1'b0;
      end else if (xfer && state == KEYS) begin
        slot <= slot == LAST ? '0 : slot + 1'b1;
        bad  <= bad || is_err;
        if (is_p1 && fresh && p1 == '0) p1 <= Byte_In;
        if (is_p2 && fresh && p2 == '0) p2 <= Byte_In;
      end
    end
  end
endmodule

// File: tb/tb_hid_keycode_packer.sv
// tb_hid_keycode_packer: directed self-checking bench for the HID keycode packer
module tb_hid_keycode_packer;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] byte_in = '0;
  logic byte_valid = 1'b0, sof = 1'b0;
  logic byte_ready, kv, err;
  logic [15:0] kc;
  int vectors = 0, miscompares = 0, strobes = 0, s0;
  logic rdy_commit, kv1;
  logic [15:0] kc1;
  hid_keycode_packer dut (
    .Clk(clk), .Reset(rst), .Byte_In(byte_in), .Byte_Valid(byte_valid),
    .Byte_Ready(byte_ready), .Sof(sof), .Keycode(kc), .Keycode_Valid(kv),
    .Rollover_Err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (kv) strobes++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic s, input logic [7:0] b);
    sof = s;
    byte_in = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    byte_valid = 1'b0;
    sof = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_report(input logic [47:0] keys);
    xfer(1'b1, 8'h00);
    xfer(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) xfer(1'b0, keys[47-8*i -: 8]);
    byte_valid = 1'b0;
    sof = 1'b0;
    rdy_commit = byte_ready;
    @(posedge clk);
    #1;
    kc1 = kc;
    kv1 = kv;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_kc", kc, 16'h0000);
    chk("reset_kv", kv, 0);
    chk("reset_err", err, 0);
    chk("reset_ready", byte_ready, 1);
    s0 = strobes;
    send_report(48'h07_00_00_00_00_00);
    chk("d_ready_commit", rdy_commit, 0);
    chk("d_kc_latency", kc1, 16'h0007);
    chk("d_kv_latency", kv1, 1);
    chk("d_kv_drop", kv, 0);
    chk("d_strobes", strobes - s0, 1);
    send_report(48'h52_07_00_00_00_00);
    chk("arrow_d_kc", kc, 16'h5207);
    send_report(48'h00_00_00_00_00_00);
    chk("release_kc", kc, 16'h0000);
    chk("release_strobe", kv1, 1);
    send_report(48'h1A_04_4F_51_00_00);
    chk("first_of_class_kc", kc, 16'h4F1A);
    send_report(48'h00_00_28_00_00_2C);
    chk("enter_space_kc", kc, 16'h282C);
    send_report(48'h00_00_00_00_00_2C);
    chk("space_kc", kc, 16'h002C);
    s0 = strobes;
    send_report(48'h01_01_01_01_01_01);
    chk("roll_kc_hold", kc, 16'h002C);
    chk("roll_no_strobe", strobes - s0, 0);
    chk("roll_err", err, 1);
    s0 = strobes;
    send_report(48'h07_00_00_00_00_03);
    chk("roll03_kc_hold", kc, 16'h002C);
    chk("roll03_no_strobe", strobes - s0, 0);
    send_report(48'h00_04_00_00_00_00);
    chk("byte04_is_p1", kc, 16'h0004);
    chk("err_sticky", err, 1);
    s0 = strobes;
    xfer(1'b1, 8'h00);
    xfer(1'b0, 8'h00);
    xfer(1'b0, 8'h52);
    xfer(1'b0, 8'h4F);
    send_report(48'h15_00_00_00_00_00);
    chk("resync_kc", kc, 16'h0015);
    chk("resync_one_strobe", strobes - s0, 1);
    s0 = strobes;
    xfer(1'b0, 8'h07);
    xfer(1'b0, 8'h52);
    xfer(1'b1, 8'h00);
    idle(3);
    xfer(1'b0, 8'h00);
    xfer(1'b0, 8'h28);
    idle(2);
    xfer(1'b0, 8'h16);
    xfer(1'b0, 8'h00);
    idle(1);
    xfer(1'b0, 8'h50);
    xfer(1'b0, 8'h1A);
    xfer(1'b0, 8'h00);
    idle(3);
    chk("gap_kc", kc, 16'h2816);
    chk("gap_one_strobe", strobes - s0, 1);
    send_report(48'h07_00_00_00_00_00);
    send_report(48'h07_00_00_00_00_00);
    chk("repeat_kc", kc1, 16'h0007);
    chk("repeat_strobe", kv1, 1);
    s0 = strobes;
    xfer(1'b1, 8'h00);
    xfer(1'b0, 8'h00);
    xfer(1'b0, 8'h4F);
    xfer(1'b0, 8'h07);
    byte_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_reset_kc", kc, 16'h0000);
    chk("mid_reset_err", err, 0);
    chk("mid_reset_ready", byte_ready, 1);
    for (int i = 0; i < 4; i++) xfer(1'b0, 8'h2C);
    idle(3);
    chk("mid_reset_no_strobe", strobes - s0, 0);
    chk("mid_reset_kc_hold", kc, 16'h0000);
    send_report(48'h00_00_00_00_51_2C);
    chk("after_reset_kc", kc, 16'h512C);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
